// File: rtl/axi_single_beat_master.sv
// axi_single_beat_master
// Turns a valid/ready command port into one single-beat (LEN=0) AXI4
// transaction at a time. Only one transaction is outstanding at any time.
// Each completion produces a one-cycle response strobe that carries the read
// data and the AXI response code.
//
// Ports
//   aclk, areset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write                     1 = write, 0 = read
//   cmd_addr/cmd_wdata/cmd_wstrb  byte address, write data and strobes
//   rsp_valid/rsp_rdata/rsp_resp  one-cycle completion pulse, read data, response
//   m_axi_aw*/w*/b*               AXI write address, write data, write response
//   m_axi_ar*/r*                  AXI read address, read data
module axi_single_beat_master #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int unsigned         STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ID_WIDTH-1:0] ID_VALUE    = ID_WIDTH'(AXI_ID);
  localparam logic [2:0]          BEAT_SIZE   = 3'($clog2(STRB_WIDTH));
  localparam logic [1:0]          BURST_INCR  = 2'b01;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state, state_next;

  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    cmd_fire, aw_fire, w_fire, b_fire, r_fire;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid & m_axi_wready;
  assign b_fire   = m_axi_bvalid & m_axi_bready;
  assign r_fire   = m_axi_rvalid & m_axi_rready;

  // Single-beat transfers only: fixed burst attributes, addresses and data
  // straight from the registers captured at command accept.
  assign m_axi_awid    = ID_VALUE;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = BEAT_SIZE;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_arid    = ID_VALUE;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = BEAT_SIZE;
  assign m_axi_arburst = BURST_INCR;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs. Valids depend only on state and the
  // per-channel done flags, never on the matching ready. In WR_ADDR_DATA a
  // channel is finished if it already completed or completes now; since its
  // valid equals ~done, "done | ready" is exactly that test.
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~areset;
        if (cmd_valid) state_next = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        m_axi_awvalid = ~aw_done;
        m_axi_wvalid  = ~w_done;
        if ((aw_done | m_axi_awready) && (w_done | m_axi_wready)) state_next = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = IDLE;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture. These registers hold the address/data/strobes stable for
  // the whole transaction, so they need no reset.
  always_ff @(posedge aclk) begin
    if (cmd_fire) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // AW/W completion tracking and the response strobe. A wrong ID or a missing
  // RLAST still consumes the beat but reports SLVERR to the requester.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      if (cmd_fire) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (b_fire) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= (m_axi_bid == ID_VALUE) ? m_axi_bresp : RESP_SLVERR;
      end
      if (r_fire) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= ((m_axi_rid == ID_VALUE) && m_axi_rlast) ? m_axi_rresp : RESP_SLVERR;
      end
    end
  end

endmodule
